// File: rtl/dw_data_qsync_mc_pkg.sv
// Shared constants and width helpers for the multi-channel quasi-synchronous data sender.
package dw_data_qsync_mc_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // clog2 that never returns 0, so a single channel still gets a 1-bit id
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int chan_w(input int channels);
        return clog2_safe(channels);
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2_safe(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dw_data_qsync_mc_fifo.sv
// Single-channel synchronous FIFO; push is refused when full, pop when empty.
module dw_data_qsync_mc_fifo
    import dw_data_qsync_mc_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW   = ptr_w(depth);
    localparam int CNTW = cnt_w(depth);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNTW-1:0]  cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CNTW'(depth));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // pointers are log2(depth) wide, so they wrap modulo depth on their own
    always_ff @(posedge clk) begin
        if (!rst_n || !init_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dw_data_qsync_mc.sv
// Multi-channel buffered sender: per-channel FIFOs, arbiter, and a stallable delay pipeline.
module dw_data_qsync_mc
    import dw_data_qsync_mc_pkg::*;
#(
    parameter int width    = 8,
    parameter int channels = 4,
    parameter int depth    = 4,
    parameter int delay    = 2,
    parameter int arb_mode = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        init_n,
    input  logic [channels-1:0]         send,
    input  logic [channels*width-1:0]   data,
    output logic [channels-1:0]         full,
    output logic [channels-1:0]         ovfl,
    input  logic                        stall_d,
    output logic                        data_avail_d,
    output logic [width-1:0]            data_d,
    output logic [chan_w(channels)-1:0] chan_d
);

    localparam int CW = chan_w(channels);

    logic [width-1:0]    fifo_rdata [channels];
    logic [channels-1:0] empty;
    logic [channels-1:0] pop_vec;
    logic [CW-1:0]       last;
    logic [CW-1:0]       grant;
    logic                grant_vld;
    logic                do_pop;
    logic [width-1:0]    pop_data;
    int                  idx;

    logic [delay-1:0]    pv;
    logic [width-1:0]    pd [delay];
    logic [CW-1:0]       pc [delay];

    for (genvar c = 0; c < channels; c++) begin : g_fifo
        dw_data_qsync_mc_fifo #(
            .width(width),
            .depth(depth)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .init_n(init_n),
            .push  (send[c]),
            .pop   (pop_vec[c]),
            .wdata (data[c*width +: width]),
            .rdata (fifo_rdata[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    // Loops run from the lowest-priority candidate upward so the last hit wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        if (arb_mode == ARB_FIXED) begin
            for (int i = channels - 1; i >= 0; i--) begin
                if (!empty[i]) begin
                    grant     = CW'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int i = channels; i >= 1; i--) begin
                idx = (int'(last) + i) % channels;
                if (!empty[idx]) begin
                    grant     = CW'(idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign do_pop   = grant_vld && !stall_d;
    assign pop_data = fifo_rdata[grant];

    always_comb begin
        pop_vec = '0;
        if (do_pop) pop_vec[grant] = 1'b1;
    end

    // Data/channel registers only load behind a valid word, so outputs hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n || !init_n) begin
            pv   <= '0;
            last <= CW'(channels - 1);
            ovfl <= '0;
            for (int k = 0; k < delay; k++) begin
                pd[k] <= '0;
                pc[k] <= '0;
            end
        end else begin
            ovfl <= ovfl | (send & full);
            if (!stall_d) begin
                pv[0] <= do_pop;
                if (do_pop) begin
                    pd[0] <= pop_data;
                    pc[0] <= grant;
                    last  <= grant;
                end
                for (int k = 1; k < delay; k++) begin
                    pv[k] <= pv[k-1];
                    if (pv[k-1]) begin
                        pd[k] <= pd[k-1];
                        pc[k] <= pc[k-1];
                    end
                end
            end
        end
    end

    assign data_avail_d = pv[delay-1];
    assign data_d       = pd[delay-1];
    assign chan_d       = pc[delay-1];

endmodule

// File: tb/tb_dw_data_qsync_mc.sv
// Scoreboard bench: round-robin instance for directed tests, fixed-priority instance for saturation.
module tb_dw_data_qsync_mc;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam int EW = CW + W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_n = 1'b1;
    logic [N-1:0]  send = '0;
    logic [N*W-1:0] data = '0;
    logic          stall_d = 1'b0;
    logic [N-1:0]  full, ovfl;
    logic          data_avail_d;
    logic [W-1:0]  data_d;
    logic [CW-1:0] chan_d;

    logic          init2_n = 1'b1;
    logic [N-1:0]  send2 = '0;
    logic [N*W-1:0] data2 = '0;
    logic          stall2_d = 1'b0;
    logic [N-1:0]  full2, ovfl2;
    logic          data_avail2_d;
    logic [W-1:0]  data2_d;
    logic [CW-1:0] chan2_d;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_q2[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dw_data_qsync_mc #(.width(W), .channels(N), .depth(4), .delay(2), .arb_mode(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .init_n(init_n), .send(send), .data(data),
        .full(full), .ovfl(ovfl), .stall_d(stall_d), .data_avail_d(data_avail_d),
        .data_d(data_d), .chan_d(chan_d)
    );

    dw_data_qsync_mc #(.width(W), .channels(N), .depth(4), .delay(2), .arb_mode(1)) u_fix (
        .clk(clk), .rst_n(rst_n), .init_n(init2_n), .send(send2), .data(data2),
        .full(full2), .ovfl(ovfl2), .stall_d(stall2_d), .data_avail_d(data_avail2_d),
        .data_d(data2_d), .chan_d(chan2_d)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && init_n && data_avail_d && !stall_d) begin
            if (exp_q.size() == 0) check("rr_unexpected", 32'({1'b1, chan_d, data_d}), 32'h0);
            else check("rr_out", 32'({chan_d, data_d}), 32'(exp_q.pop_front()));
        end
        if (rst_n && init2_n && data_avail2_d && !stall2_d) begin
            if (exp_q2.size() == 0) check("fix_unexpected", 32'({1'b1, chan2_d, data2_d}), 32'h0);
            else check("fix_out", 32'({chan2_d, data2_d}), 32'(exp_q2.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || exp_q2.size() != 0); i++) tick();
        check("drain_left", 32'(exp_q.size() + exp_q2.size()), 32'h0);
        repeat (4) tick();
    endtask

    task automatic drive(input int c, input logic [W-1:0] v);
        send[c] = 1'b1;
        data[c*W +: W] = v;
        exp_q.push_back({CW'(c), v});
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_avail", 32'(data_avail_d), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_ovfl", 32'(ovfl), 32'h0);
        check("rst_data", 32'({chan_d, data_d}), 32'h0);

        // 1: single word latency
        do_reset();
        drive(2, 8'hA5);
        tick();
        send = '0;
        check("t1_c1_avail", 32'(data_avail_d), 32'h0);
        tick();
        check("t1_c2_avail", 32'(data_avail_d), 32'h0);
        tick();
        check("t1_c3_avail", 32'(data_avail_d), 32'h1);
        check("t1_c3_word", 32'({chan_d, data_d}), 32'({2'd2, 8'hA5}));
        tick();
        check("t1_c4_avail", 32'(data_avail_d), 32'h0);
        check("t1_hold", 32'(data_d), 32'hA5);
        wait_drain();

        // 2: round-robin across three simultaneous sends
        do_reset();
        drive(0, 8'h11); drive(1, 8'h22); drive(3, 8'h33);
        tick();
        send = '0;
        tick(); tick();
        check("t2_c3_word", 32'({data_avail_d, chan_d, data_d}), 32'({1'b1, 2'd0, 8'h11}));
        wait_drain();

        // 3: fill under stall, overflow, then release
        stall_d = 1'b1;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) drive(1, 8'(i));
            else begin send[1] = 1'b1; data[W +: W] = 8'(i); end
            tick();
            if (i == 4) check("t3_full_after4", 32'(full), 32'h2);
        end
        send = '0;
        check("t3_ovfl", 32'(ovfl), 32'h2);
        check("t3_full", 32'(full), 32'h2);
        check("t3_stalled_avail", 32'(data_avail_d), 32'h0);
        stall_d = 1'b0;
        wait_drain();
        check("t3_ovfl_sticky", 32'(ovfl), 32'h2);
        check("t3_full_clr", 32'(full), 32'h0);

        // 4: stall while presenting 0x22
        do_reset();
        drive(0, 8'h11); drive(1, 8'h22); drive(3, 8'h33);
        tick();
        send = '0;
        repeat (3) tick();
        stall_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4_hold", 32'({data_avail_d, chan_d, data_d}), 32'({1'b1, 2'd1, 8'h22}));
            tick();
        end
        stall_d = 1'b0;
        wait_drain();

        // 5: soft init clears state and restores channel 0 priority
        do_reset();
        drive(1, 8'h77);
        tick();
        send = '0;
        wait_drain();
        stall_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send[1] = 1'b1; data[W +: W] = 8'h80 + 8'(i);
            send[2] = (i == 0);
            data[2*W +: W] = 8'h90;
            tick();
        end
        send = '0;
        check("t5_pre_ovfl", 32'(ovfl), 32'h2);
        check("t5_pre_full", 32'(full), 32'h2);
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        check("t5_avail", 32'(data_avail_d), 32'h0);
        check("t5_full", 32'(full), 32'h0);
        check("t5_ovfl", 32'(ovfl), 32'h0);
        check("t5_data", 32'({chan_d, data_d}), 32'h0);
        stall_d = 1'b0;
        drive(0, 8'h5A); drive(2, 8'h6B);
        tick();
        send = '0;
        wait_drain();

        // 6: saturation on both arbitration modes
        do_reset();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < N; c++) exp_q.push_back({CW'(c), 8'h40 + 8'(c)});
        for (int i = 0; i < 6; i++) exp_q2.push_back({2'd0, 8'h40});
        for (int c = 1; c < N; c++)
            for (int i = 0; i < 4; i++) exp_q2.push_back({CW'(c), 8'h40 + 8'(c)});
        data  = {8'h43, 8'h42, 8'h41, 8'h40};
        data2 = {8'h43, 8'h42, 8'h41, 8'h40};
        send  = '1;
        send2 = '1;
        repeat (6) tick();
        send  = '0;
        send2 = '0;
        check("t6_rr_ovfl", 32'(ovfl), 32'hF);
        check("t6_fix_ovfl", 32'(ovfl2), 32'hE);
        check("t6_fix_full", 32'(full2), 32'hE);
        wait_drain();
        check("t6_rr_full_end", 32'(full), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
